// File: rtl/arcade_input_arbiter.sv
// Shares one arcade control set between two Pocket pads: activity-based ownership with idle
// release and Start handover, plus Select-to-coin pulse shaping for each player.
module arcade_input_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned COIN_PULSE     = 65536,
    parameter int unsigned CW             = 21
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [15:0] p1_keys,
    input  logic [15:0] p2_keys,
    input  logic        lock,
    output logic [11:0] m_ctrl,
    output logic        m_start1,
    output logic        m_start2,
    output logic        m_coin1,
    output logic        m_coin2,
    output logic [1:0]  owner,
    output logic        owner_chg
);

    // State encoding doubles as the owner code driven on the owner port.
    localparam logic [1:0] StIdle  = 2'b00;
    localparam logic [1:0] StOwnP1 = 2'b01;
    localparam logic [1:0] StOwnP2 = 2'b10;

    localparam logic [CW-1:0] IdleLast = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CoinLast = CW'(COIN_PULSE - 1);

    // {btn8..btn1, right, left, down, up} with btn1..btn8 = y, b, a, x, l1, r1, l2, r2.
    function automatic logic [11:0] remap(input logic [15:0] k);
        return {k[11], k[10], k[9], k[8], k[6], k[4], k[5], k[7], k[3:0]};
    endfunction

    logic [1:0]    state_q, state_d;
    logic [1:0]    last_q, last_d;
    logic [CW-1:0] idle_cnt_q, idle_cnt_d;
    logic [CW-1:0] coin1_cnt_q, coin2_cnt_q;
    logic          se1_q, se2_q;

    logic act1, act2, st1_rise, st2_rise, se1_rise, se2_rise;
    logic req1, req2;
    logic own_act, other_st, self_st;
    logic [1:0] other;
    logic unused_keys;

    assign unused_keys = ^{p1_keys[13:12], p2_keys[13:12]};

    assign act1     = |p1_keys[11:0];
    assign act2     = |p2_keys[11:0];
    // m_startN is the registered start bit, so it also serves as the edge-detect history.
    assign st1_rise = p1_keys[15] & ~m_start1;
    assign st2_rise = p2_keys[15] & ~m_start2;
    assign se1_rise = p1_keys[14] & ~se1_q;
    assign se2_rise = p2_keys[14] & ~se2_q;
    assign req1     = act1 | st1_rise;
    assign req2     = act2 | st2_rise;

    assign own_act  = (state_q == StOwnP1) ? act1 : act2;
    assign other_st = (state_q == StOwnP1) ? st2_rise : st1_rise;
    assign self_st  = (state_q == StOwnP1) ? st1_rise : st2_rise;
    assign other    = (state_q == StOwnP1) ? StOwnP2 : StOwnP1;

    assign owner = state_q;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        idle_cnt_d = idle_cnt_q;
        case (state_q)
            StIdle: begin
                idle_cnt_d = '0;
                if (req1 && req2) begin
                    state_d = (last_q == StOwnP1) ? StOwnP2 : StOwnP1;
                end else if (req1) begin
                    state_d = StOwnP1;
                end else if (req2) begin
                    state_d = StOwnP2;
                end
            end
            StOwnP1, StOwnP2: begin
                if (!lock && other_st && !self_st) begin
                    state_d    = other;
                    last_d     = state_q;
                    idle_cnt_d = '0;
                end else if (own_act || lock) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IdleLast) begin
                    state_d    = StIdle;
                    last_d     = state_q;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = StIdle;
                idle_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            last_q     <= StOwnP2;
            idle_cnt_q <= '0;
            owner_chg  <= 1'b0;
            m_ctrl     <= '0;
            m_start1   <= 1'b0;
            m_start2   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            idle_cnt_q <= idle_cnt_d;
            owner_chg  <= (state_d != state_q);
            m_start1   <= p1_keys[15];
            m_start2   <= p2_keys[15];
            if (state_d == StOwnP1) begin
                m_ctrl <= remap(p1_keys);
            end else if (state_d == StOwnP2) begin
                m_ctrl <= remap(p2_keys);
            end else begin
                m_ctrl <= '0;
            end
        end
    end

    // Coin pulses ignore ownership and lock; edges during an active pulse are dropped.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            se1_q       <= 1'b0;
            se2_q       <= 1'b0;
            m_coin1     <= 1'b0;
            m_coin2     <= 1'b0;
            coin1_cnt_q <= '0;
            coin2_cnt_q <= '0;
        end else begin
            se1_q <= p1_keys[14];
            se2_q <= p2_keys[14];

            if (m_coin1) begin
                if (coin1_cnt_q == CoinLast) begin
                    m_coin1     <= 1'b0;
                    coin1_cnt_q <= '0;
                end else begin
                    coin1_cnt_q <= coin1_cnt_q + 1'b1;
                end
            end else if (se1_rise) begin
                m_coin1     <= 1'b1;
                coin1_cnt_q <= '0;
            end

            if (m_coin2) begin
                if (coin2_cnt_q == CoinLast) begin
                    m_coin2     <= 1'b0;
                    coin2_cnt_q <= '0;
                end else begin
                    coin2_cnt_q <= coin2_cnt_q + 1'b1;
                end
            end else if (se2_rise) begin
                m_coin2     <= 1'b1;
                coin2_cnt_q <= '0;
            end
        end
    end

endmodule

// File: doc/arcade_input_arbiter.md
Name: arcade_input_arbiter

Overview:
- Shares the single arcade control set (stick, 8 buttons) between two Pocket pads for alternating two-player arcade cores.
- Sits between the gamepad decoder outputs (P1/P2 key bitmaps) and the core's input port.
- Grants ownership by activity, releases it on an idle timeout, and hands it over on a Start press.
- Shapes Select presses into fixed-width coin pulses.

Parameters:
- TIMEOUT_CYCLES, 1048576: consecutive owner-idle cycles before ownership is released; minimum 2.
- COIN_PULSE, 65536: width of an m_coinN pulse in clk_sys cycles; minimum 1.
- CW, 21: counter width; must hold max(TIMEOUT_CYCLES, COIN_PULSE).

Ports:
- clk_sys, input, 1: system clock.
- reset_n, input, 1: asynchronous, active-low reset.
- p1_keys, input, 16: P1 key bitmap.
  - Bits [0] up, [1] down, [2] left, [3] right, [4] a, [5] b, [6] x, [7] y.
  - Bits [8] l1, [9] r1, [10] l2, [11] r2, [12] l3, [13] r3, [14] select, [15] start.
  - Synchronous to clk_sys.
- p2_keys, input, 16: P2 key bitmap, same layout.
- lock, input, 1: core-driven; while high, the current owner is never released or handed over.
- m_ctrl, output, 12: {btn8..btn1, right, left, down, up}.
  - btn1=y, btn2=b, btn3=a, btn4=x, btn5=l1, btn6=r1, btn7=l2, btn8=r2.
- m_start1, output, 1: registered p1 start.
- m_start2, output, 1: registered p2 start.
- m_coin1, output, 1: P1 coin pulse.
- m_coin2, output, 1: P2 coin pulse.
- owner, output, 2: 00 none, 01 P1, 10 P2.
- owner_chg, output, 1: one-cycle pulse when owner changes, including release to none.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All outputs 0; state IDLE; last_owner=P2, so P1 wins the first tie.
  - Idle and coin counters 0; edge-detect registers 0.
  - Reset mid-pulse truncates the coin pulse.
  - Reset mid-ownership drops to IDLE with no owner_chg pulse.
- Activity: actN = |pN_keys[11:0]. Start edge: stN_rise = pN_keys[15] & ~prev. Select edge: seN_rise likewise on bit 14.
- FSM states: IDLE, OWN_P1, OWN_P2.
  - IDLE, exactly one of act1/act2 set: go to that player's OWN state.
  - IDLE, both set in the same cycle: grant to the player that is not last_owner.
  - IDLE, start edge with no activity: grants to that player; same tie rule applies.
  - OWN_Px: other player's activity is ignored.
  - OWN_Px, lock=0, other player's st_rise: hand over to the other player (one transition, owner_chg=1).
  - Both start edges in the same cycle: no handover.
  - OWN_Px, idle counting: counter increments on cycles with actx=0 and lock=0; clears on actx=1 or lock=1.
  - OWN_Px, release: when the counter reaches TIMEOUT_CYCLES-1 with the condition still true, go to IDLE. That is exactly TIMEOUT_CYCLES idle cycles.
  - On leaving any OWN state, last_owner is set to that owner.
- owner and owner_chg are registered from next-state, so they are valid the cycle after the causing input.
- m_ctrl:
  - m_ctrl <= remap(keys of next-state owner), else 0.
  - One-cycle latency, including the cycle of the granting activity.
  - On handover, the old owner's bits never appear after the transition edge.
- m_startN: registered pN_keys[15]; not arbitrated.
- Coin:
  - seN_rise while m_coinN=0: m_coinN=1 for exactly COIN_PULSE cycles, starting the cycle after the edge.
  - Edges while the pulse is active are ignored (no retrigger).
  - A held Select gives a single pulse.
  - P1 and P2 coins are independent and may overlap.
- Coin logic is not affected by ownership or lock.

Test Plan:
Bench parameters: TIMEOUT_CYCLES=16, COIN_PULSE=4.
- Reset release, all keys 0 -> all outputs 0, owner=00 for 50 cycles.
- p1_keys=0x0001 for one cycle, then 0 -> next cycle: owner=01, owner_chg=1, m_ctrl=0x001.
  - owner stays 01 for 16 idle cycles, then 00 with owner_chg=1.
  - p2 activity during ownership gives m_ctrl=0.
- p1_keys=0x0020 and p2_keys=0x0010 in the same cycle from reset -> owner=01, m_ctrl=0x020 (btn2).
  - After timeout, repeat the simultaneous press -> owner=10, m_ctrl=0x040 (btn3).
- P1 owns, lock=0, p2_keys bit15 rises -> owner=10 next cycle, m_start2=1, owner_chg=1.
  - Repeat with lock=1 -> owner stays 01.
  - Hold lock=1 with P1 idle for 40 cycles -> no release.
- p1_keys bit14 held 10 cycles -> m_coin1 high exactly 4 cycles, starting 1 cycle after the edge.
  - Second edge during the pulse -> no extension.
  - Simultaneous p2 edge -> m_coin2 pulses independently.
- Assert reset_n low during an active coin pulse with owner=10 -> m_coin1, m_ctrl and owner go to 0 immediately (asynchronous).
  - After release, the first tie grants P1.
